// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle RV32 control FSM and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             pc_source;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_write;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       aluop;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, aluop,
           illegal, state, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, aluop,
           illegal, state, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32 datapath: sequences instruction
// phases, stalls on mem_ready, traps on unsupported opcodes, counts retirements.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);
  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEM_ADDR  = 4'd2;
  localparam logic [3:0] MEM_READ  = 4'd3;
  localparam logic [3:0] MEM_WB    = 4'd4;
  localparam logic [3:0] MEM_WRITE = 4'd5;
  localparam logic [3:0] EXECUTE   = 4'd6;
  localparam logic [3:0] ALU_WB    = 4'd7;
  localparam logic [3:0] BRANCH    = 4'd8;
  localparam logic [3:0] TRAP      = 4'd9;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [3:0]       state_q;
  logic [3:0]       state_d;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;
  logic             retire;

  always_comb begin
    state_d = FETCH;
    retire  = 1'b0;
    case (state_q)
      FETCH:    state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_R:               state_d = EXECUTE;
          OP_LOAD, OP_STORE:  state_d = MEM_ADDR;
          OP_BRANCH:          state_d = BRANCH;
          default:            state_d = TRAP;
        endcase
      end
      MEM_ADDR: state_d = (bus.opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
      MEM_READ: state_d = bus.mem_ready ? MEM_WB : MEM_READ;
      MEM_WB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      MEM_WRITE: begin
        state_d = bus.mem_ready ? FETCH : MEM_WRITE;
        retire  = bus.mem_ready;
      end
      EXECUTE:  state_d = ALU_WB;
      ALU_WB, BRANCH: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
      if (state_d == TRAP) illegal_q <= 1'b1;
    end
  end

  // Outputs are Moore decodes of state; during reset every enable/select is held at 0.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_source     = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 2'b00;
    bus.alu_src_b     = 2'b00;
    bus.aluop         = 2'b00;
    if (rst) begin
      case (state_q)
        FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        DECODE:   bus.alu_src_b = 2'b10;
        MEM_ADDR: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b10;
        end
        MEM_READ: begin
          bus.mem_read = 1'b1;
          bus.iord     = 1'b1;
        end
        MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        MEM_WRITE: begin
          bus.mem_write = 1'b1;
          bus.iord      = 1'b1;
        end
        EXECUTE: begin
          bus.alu_src_a = 2'b01;
          bus.aluop     = 2'b10;
        end
        ALU_WB:   bus.reg_write = 1'b1;
        BRANCH: begin
          bus.alu_src_a     = 2'b01;
          bus.aluop         = 2'b01;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state   = rst ? state_q : 4'd0;
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction expected state traces
// built from the instruction class and stall plan, plus directed reset/trap/wrap cases.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst4 = 1'b0;
  int total = 0;
  int bad = 0;
  int exp_retired = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) bus32 ();
  multicycle_control_if #(.CNT_W(4))  bus4 ();

  multicycle_control #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus32));
  multicycle_control #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst4), .bus(bus4));

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MADDR = 2, ST_MREAD = 3, ST_MWB = 4,
                 ST_MWRITE = 5, ST_EXEC = 6, ST_AWB = 7, ST_BRANCH = 8, ST_TRAP = 9;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
  //  ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, aluop}
  function automatic logic [14:0] get_ctrl();
    return {bus32.pc_write, bus32.pc_write_cond, bus32.pc_source, bus32.iord,
            bus32.mem_read, bus32.mem_write, bus32.ir_write, bus32.mem_to_reg,
            bus32.reg_write, bus32.alu_src_a, bus32.alu_src_b, bus32.aluop};
  endfunction

  function automatic logic [14:0] exp_ctrl(input int st, input logic rdy);
    logic pw = 0, pwc = 0, psrc = 0, io = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rw = 0;
    logic [1:0] a = 2'b00, b = 2'b00, op = 2'b00;
    case (st)
      ST_FETCH:  begin mr = 1; b = 2'b01; irw = rdy; pw = rdy; end
      ST_DECODE: b = 2'b10;
      ST_MADDR:  begin a = 2'b01; b = 2'b10; end
      ST_MREAD:  begin mr = 1; io = 1; end
      ST_MWB:    begin rw = 1; m2r = 1; end
      ST_MWRITE: begin mw = 1; io = 1; end
      ST_EXEC:   begin a = 2'b01; op = 2'b10; end
      ST_AWB:    rw = 1;
      ST_BRANCH: begin a = 2'b01; op = 2'b01; pwc = 1; psrc = 1; end
      default: ;
    endcase
    return {pw, pwc, psrc, io, mr, mw, irw, m2r, rw, a, b, op};
  endfunction

  // cls: 0 = R-type, 1 = lw, 2 = sw, 3 = beq
  task automatic run_instr(input int cls, input int f_stall, input int m_stall,
                           output int cycles, output int irw_count);
    int st_q[$];
    logic rdy_q[$];
    logic [6:0] opc [4] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011};
    bus32.opcode = opc[cls];
    for (int i = 0; i < f_stall; i++) begin st_q.push_back(ST_FETCH); rdy_q.push_back(1'b0); end
    st_q.push_back(ST_FETCH); rdy_q.push_back(1'b1);
    st_q.push_back(ST_DECODE); rdy_q.push_back(1'($urandom));
    case (cls)
      0: begin
        st_q.push_back(ST_EXEC); rdy_q.push_back(1'($urandom));
        st_q.push_back(ST_AWB);  rdy_q.push_back(1'($urandom));
      end
      1: begin
        st_q.push_back(ST_MADDR); rdy_q.push_back(1'($urandom));
        for (int i = 0; i < m_stall; i++) begin st_q.push_back(ST_MREAD); rdy_q.push_back(1'b0); end
        st_q.push_back(ST_MREAD); rdy_q.push_back(1'b1);
        st_q.push_back(ST_MWB);   rdy_q.push_back(1'($urandom));
      end
      2: begin
        st_q.push_back(ST_MADDR); rdy_q.push_back(1'($urandom));
        for (int i = 0; i < m_stall; i++) begin st_q.push_back(ST_MWRITE); rdy_q.push_back(1'b0); end
        st_q.push_back(ST_MWRITE); rdy_q.push_back(1'b1);
      end
      default: begin
        st_q.push_back(ST_BRANCH); rdy_q.push_back(1'($urandom));
      end
    endcase
    cycles = st_q.size();
    irw_count = 0;
    for (int i = 0; i < st_q.size(); i++) begin
      @(negedge clk);
      bus32.mem_ready = rdy_q[i];
      #1;
      check("state", 32'(bus32.state), 32'(st_q[i]));
      check("ctrl", 32'(get_ctrl()), 32'(exp_ctrl(st_q[i], rdy_q[i])));
      check("illegal", 32'(bus32.illegal), 32'd0);
      if (bus32.ir_write) irw_count++;
      @(posedge clk);
    end
    exp_retired++;
    #1;
    check("retired", bus32.retired, 32'(exp_retired));
    check("state_end", 32'(bus32.state), 32'(ST_FETCH));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    bus32.mem_ready = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rst_state", 32'(bus32.state), 32'd0);
      check("rst_ctrl", 32'(get_ctrl()), 32'd0);
      check("rst_retired", bus32.retired, 32'd0);
      check("rst_illegal", 32'(bus32.illegal), 32'd0);
    end
    exp_retired = 0;
    @(negedge clk);
    rst = 1'b1;
    bus32.mem_ready = 1'b0;
    #1;
    check("rel_state", 32'(bus32.state), 32'd0);
    check("rel_ctrl", 32'(get_ctrl()), 32'(exp_ctrl(ST_FETCH, 1'b0)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, irw;
    bus32.opcode = 7'b0110011;
    bus32.mem_ready = 1'b1;
    bus4.opcode = 7'b0110011;
    bus4.mem_ready = 1'b1;

    do_reset(3);

    run_instr(0, 0, 0, cyc, irw);
    check("rtype_cycles", 32'(cyc), 32'd4);
    run_instr(1, 2, 3, cyc, irw);
    check("lw_cycles", 32'(cyc), 32'd10);
    check("lw_irw_once", 32'(irw), 32'd1);
    run_instr(2, 0, 0, cyc, irw);
    check("sw_cycles", 32'(cyc), 32'd4);
    run_instr(3, 0, 0, cyc, irw);
    check("beq_cycles", 32'(cyc), 32'd3);

    for (int k = 0; k < 40; k++) begin
      int cls;
      cls = int'($urandom_range(0, 3));
      run_instr(cls, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), cyc, irw);
      check("irw_once", 32'(irw), 32'd1);
    end

    // Illegal opcode traps after DECODE and never fetches again.
    bus32.opcode = 7'b1111111;
    @(negedge clk); bus32.mem_ready = 1'b1; #1;
    check("trap_fetch", 32'(bus32.state), 32'(ST_FETCH));
    @(posedge clk);
    @(negedge clk); #1;
    check("trap_decode", 32'(bus32.state), 32'(ST_DECODE));
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus32.mem_ready = 1'($urandom);
      #1;
      check("trap_state", 32'(bus32.state), 32'(ST_TRAP));
      check("trap_ctrl", 32'(get_ctrl()), 32'd0);
      check("trap_illegal", 32'(bus32.illegal), 32'd1);
      check("trap_retired", bus32.retired, 32'(exp_retired));
      @(posedge clk);
    end
    do_reset(1);

    // Reset during a MEM_READ stall abandons the access.
    run_instr(0, 0, 0, cyc, irw);
    bus32.opcode = 7'b0000011;
    @(negedge clk); bus32.mem_ready = 1'b1; @(posedge clk);
    @(negedge clk); @(posedge clk);
    @(negedge clk); @(posedge clk);
    @(negedge clk); bus32.mem_ready = 1'b0; #1;
    check("stall_state", 32'(bus32.state), 32'(ST_MREAD));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_state", 32'(bus32.state), 32'd0);
    check("midrst_ctrl", 32'(get_ctrl()), 32'd0);
    @(posedge clk); #1;
    check("midrst_retired", bus32.retired, 32'd0);
    exp_retired = 0;
    @(negedge clk);
    rst = 1'b1;
    bus32.mem_ready = 1'b0;
    #1;
    check("midrst_fetch", 32'(get_ctrl()), 32'(exp_ctrl(ST_FETCH, 1'b0)));
    run_instr(2, 1, 1, cyc, irw);

    // 4-bit counter wraps after 16 retirements.
    @(negedge clk);
    rst4 = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      repeat (4) @(posedge clk);
      #1;
      check("wrap_retired", 32'(bus4.retired), 32'(n % 16));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32 datapath.
- Sequences fetch, decode, execute, memory and writeback from the IR opcode.
- Produces the 2-bit aluop that feeds the ALU control decoder, plus all datapath enables and mux selects.
- Stalls on a memory ready handshake, traps on unsupported opcodes and counts retired instructions.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous active-low reset.
- opcode  input  7  IR[6:0]; stable from DECODE onward.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load qualified by ALU zero (branch).
- pc_source  output  1  0 = ALU result, 1 = ALUOut register.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR load enable.
- mem_to_reg  output  1  writeback select: 0 = ALUOut, 1 = MDR.
- reg_write  output  1  register file write enable.
- alu_src_a  output  2  00 = PC, 01 = reg A, others reserved (drive 00).
- alu_src_b  output  2  00 = reg B, 01 = constant 4, 10 = immediate, 11 reserved.
- aluop  output  2  00 = add, 01 = sub (branch compare), 10 = funct-decoded.
- illegal  output  1  sticky trap flag.
- state  output  4  current state encoding, for debug.
- retired  output  CNT_W  retired-instruction count.

Behaviour:
- State encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, TRAP=9.
  - Encodings 10-15 are unreachable; if entered, next state is FETCH.
- Reset:
  - While rst=0 at a clock edge: state<=FETCH, retired<=0, illegal<=0.
  - While rst=0, all enables (pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write) are forced 0 combinationally.
  - While rst=0, selects and aluop = 0; state output = 0.
  - Reset mid-access abandons the access; no completion is pending afterwards.
- Outputs are Moore, decoded from state. Every signal not listed for a state is 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, aluop=00, pc_source=0.
  - ir_write=mem_ready, pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=00, alu_src_b=10, aluop=00 (branch target into ALUOut).
  - Next state by opcode:
    - 0110011 -> EXECUTE
    - 0000011 or 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - any other opcode -> TRAP
- MEM_ADDR:
  - alu_src_a=01, alu_src_b=10, aluop=00.
  - Next state: 0000011 -> MEM_READ, else MEM_WRITE.
- MEM_READ:
  - mem_read=1, iord=1.
  - Waits for mem_ready, then goes to MEM_WB.
- MEM_WB:
  - reg_write=1, mem_to_reg=1; next state FETCH.
- MEM_WRITE:
  - mem_write=1, iord=1.
  - Waits for mem_ready, then goes to FETCH.
- EXECUTE:
  - alu_src_a=01, alu_src_b=00, aluop=10; next state ALU_WB.
- ALU_WB:
  - reg_write=1, mem_to_reg=0; next state FETCH.
- BRANCH:
  - alu_src_a=01, alu_src_b=00, aluop=01, pc_write_cond=1, pc_source=1; next state FETCH.
- TRAP:
  - illegal<=1 on entry; all enables 0.
  - Remains in TRAP until reset. No further fetches occur.
- Latency with mem_ready tied high, counting from the FETCH cycle:
  - R-type: 4 cycles. lw: 5 cycles. sw: 4 cycles. beq: 3 cycles.
  - Each low cycle of mem_ready in FETCH, MEM_READ or MEM_WRITE adds 1 cycle.
- Memory handshake:
  - mem_read and mem_write are held constant while waiting.
  - mem_ready is ignored in every state other than FETCH, MEM_READ and MEM_WRITE.
- retired counter:
  - Increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE (with mem_ready=1), ALU_WB or BRANCH.
  - Wraps modulo 2^CNT_W with no flag.
  - Does not increment on reset or on entry to TRAP.

Test Plan:
- Reset: hold rst=0 for 3 cycles with mem_ready=1 -> state=0, all enables 0, retired=0, illegal=0; first cycle after release shows mem_read=1, iord=0, alu_src_b=01.
- R-type: opcode=0110011, mem_ready=1 -> states 0,1,6,7,0; aluop=10 in EXECUTE; reg_write=1, mem_to_reg=0 in ALU_WB; retired=1.
- lw with stalls: opcode=0000011, mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_READ -> 10 cycles total; ir_write pulses exactly once; mem_to_reg=1 with reg_write=1 in MEM_WB.
- sw then beq: opcode=0100011 -> states 0,1,2,5,0 with mem_write=1 and iord=1 in MEM_WRITE; then opcode=1100011 -> states 0,1,8,0 with aluop=01, pc_write_cond=1, pc_source=1; retired increments by 2.
- Illegal opcode 1111111 -> TRAP after DECODE, illegal=1, no mem_read for 20 cycles; rst=0 for one cycle clears illegal and returns to FETCH.
- Counter wrap, CNT_W=4: run 17 R-type instructions -> retired reads 15 after the 15th, 0 after the 16th, 1 after the 17th. Separately, rst=0 asserted during a MEM_READ stall -> state=0, retired=0.
